// File: rtl/lfsr_pkg.sv
// Shared constants, scheduler state type and the LFSR step function for the
// two-channel keystream scheduler.
package lfsr_pkg;

    localparam int                LFSR_W          = 8;
    localparam logic [LFSR_W-1:0] LFSR_TAPS       = 8'hE1;
    localparam logic [LFSR_W-1:0] LFSR_RESET_SEED = 8'h41;
    localparam int                NUM_CH          = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WARM = 1'b1
    } sched_state_t;

    // Fibonacci step: shift left, feedback is the parity of the tapped bits.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] taps);
        return {s[LFSR_W-2:0], ^(s & taps)};
    endfunction

endpackage

// File: rtl/lfsr_ctx_bank.sv
// Per-channel LFSR context registers. A seed load beats a step on the same
// channel; a zero seed is replaced by RESET_SEED so no context can lock up.
module lfsr_ctx_bank
    import lfsr_pkg::*;
#(
    parameter int                NUM_CH     = 2,
    parameter int                WIDTH      = LFSR_W,
    parameter logic [WIDTH-1:0]  TAPS       = LFSR_TAPS,
    parameter logic [WIDTH-1:0]  RESET_SEED = LFSR_RESET_SEED
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_CH-1:0]             ld_en,
    input  logic [WIDTH-1:0]              ld_seed,
    input  logic [NUM_CH-1:0]             step_en,
    output logic [NUM_CH-1:0][WIDTH-1:0]  ctx,
    output logic                          seed_zero
);

    logic [WIDTH-1:0] ld_val;

    assign seed_zero = (ld_seed == '0);
    assign ld_val    = seed_zero ? RESET_SEED : ld_seed;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [WIDTH-1:0] state;

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                state <= RESET_SEED;
            else if (ld_en[g])
                state <= ld_val;
            else if (step_en[g])
                state <= lfsr_step(state, TAPS);
        end

        assign ctx[g] = state;
    end

endmodule

// File: rtl/lfsr_keystream_sched.sv
// Two-channel round-robin byte encryptor sharing one LFSR keystream engine,
// with per-channel reseed and a discard (warm-up) run after each seed load.
module lfsr_keystream_sched
    import lfsr_pkg::*;
#(
    parameter int                WIDTH      = LFSR_W,
    parameter logic [WIDTH-1:0]  TAPS       = LFSR_TAPS,
    parameter logic [WIDTH-1:0]  RESET_SEED = LFSR_RESET_SEED,
    parameter int                WARMUP     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        in_valid,
    input  logic [WIDTH-1:0]  in_data0,
    input  logic [WIDTH-1:0]  in_data1,
    output logic [1:0]        in_ready,
    input  logic              cfg_we,
    input  logic              cfg_ch,
    input  logic [WIDTH-1:0]  cfg_seed,
    output logic              cfg_err,
    output logic              out_valid,
    output logic [WIDTH-1:0]  out_data,
    output logic              out_ch,
    input  logic              out_ready,
    output logic              busy
);

    localparam int              CNT_W     = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;
    localparam logic [CNT_W-1:0] WARM_LOAD = CNT_W'(WARMUP);
    localparam logic            WARM_EN   = (WARMUP > 0);

    sched_state_t             state, state_nxt;
    logic                     warm_ch, warm_ch_nxt;
    logic [CNT_W-1:0]         cnt, cnt_nxt;
    logic [1:0]               pending, pending_nxt;
    logic                     rr, rr_nxt;
    logic [1:0]               grant, warm_step, ld_en, eligible;
    logic                     slot_free, sel_ch, seed_zero;
    logic [WIDTH-1:0]         sel_data;
    logic [1:0][WIDTH-1:0]    ctx;

    assign ld_en     = cfg_we ? (2'b01 << cfg_ch) : 2'b00;
    assign slot_free = !out_valid || out_ready;
    // A seed load to a channel blocks its grant in the same cycle.
    assign eligible  = in_valid & ~ld_en;

    lfsr_ctx_bank #(
        .NUM_CH     (2),
        .WIDTH      (WIDTH),
        .TAPS       (TAPS),
        .RESET_SEED (RESET_SEED)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .ld_en     (ld_en),
        .ld_seed   (cfg_seed),
        .step_en   (grant | warm_step),
        .ctx       (ctx),
        .seed_zero (seed_zero)
    );

    always_comb begin
        state_nxt   = state;
        warm_ch_nxt = warm_ch;
        cnt_nxt     = cnt;
        rr_nxt      = rr;
        grant       = 2'b00;
        warm_step   = 2'b00;
        pending_nxt = pending;
        if (cfg_we && WARM_EN)
            pending_nxt[cfg_ch] = 1'b1;

        case (state)
            IDLE: begin
                if (WARM_EN && (|pending)) begin
                    state_nxt   = WARM;
                    warm_ch_nxt = !pending[0];
                    cnt_nxt     = WARM_LOAD;
                end else if (slot_free) begin
                    if (eligible == 2'b11) begin
                        grant  = rr ? 2'b10 : 2'b01;
                        rr_nxt = !rr;
                    end else begin
                        grant = eligible;
                    end
                end
            end
            WARM: begin
                warm_step[warm_ch] = 1'b1;
                if (cfg_we && (cfg_ch == warm_ch)) begin
                    cnt_nxt = WARM_LOAD;
                end else if (cnt <= CNT_W'(1)) begin
                    pending_nxt[warm_ch] = 1'b0;
                    state_nxt            = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready = grant;
    assign busy     = (state == WARM);
    assign sel_ch   = grant[1];
    assign sel_data = sel_ch ? in_data1 : in_data0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            warm_ch   <= 1'b0;
            cnt       <= '0;
            pending   <= 2'b00;
            rr        <= 1'b0;
            cfg_err   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= 1'b0;
        end else begin
            state   <= state_nxt;
            warm_ch <= warm_ch_nxt;
            cnt     <= cnt_nxt;
            pending <= pending_nxt;
            rr      <= rr_nxt;
            cfg_err <= cfg_we && seed_zero;
            if (|grant) begin
                out_valid <= 1'b1;
                out_data  <= sel_data ^ ctx[sel_ch];
                out_ch    <= sel_ch;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
